// File: rtl/parking_pkg.sv
// Shared constants and types for the parking lot gate controller.
// Timer width is derived from the gate-open duration.
package parking_pkg;

  localparam int N_SPOTS         = 8;
  localparam int SPOT_W          = 3;
  localparam int CNT_W           = 4;
  localparam int GATE_CYCLES_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_e;

  // The timer counts GATE_CYCLES-1 down to 0, so it needs at least one bit.
  function automatic int tmr_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

  localparam int TMR_W_DEF = tmr_width(GATE_CYCLES_DEF);

endpackage

// File: rtl/parking_gate_ctrl_lowest_free_enc.sv
// Priority encoder that picks the lowest-index free spot.
// It also flags the case where no spot is free.
module lowest_free_enc
  import parking_pkg::*;
(
  input  logic [N_SPOTS-1:0] occ,
  output logic [SPOT_W-1:0]  idx,
  output logic               none_free
);

  always_comb begin
    idx = '0;
    for (int i = N_SPOTS - 1; i >= 0; i--) begin
      if (!occ[i]) idx = SPOT_W'(i);
    end
    none_free = &occ;
  end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking lot controller: owns the occupancy map, allocates and releases spots,
// and holds the barrier open for GATE_CYCLES cycles after each accepted event.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               entry_req,
  input  logic               exit_req,
  input  logic [SPOT_W-1:0]  exit_spot,
  output logic               entry_ack,
  output logic               entry_deny,
  output logic [SPOT_W-1:0]  assigned_spot,
  output logic               exit_ack,
  output logic               exit_err,
  output logic               gate_open,
  output logic [N_SPOTS-1:0] occ,
  output logic [CNT_W-1:0]   free_cnt,
  output logic               full
);

  localparam int               TMR_W    = tmr_width(GATE_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(GATE_CYCLES - 1);

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [N_SPOTS-1:0] occ_q, occ_d;
  logic [CNT_W-1:0]   free_q, free_d;
  logic               full_q, full_d;
  logic [SPOT_W-1:0]  spot_q, spot_d;
  logic               eack_q, eack_d;
  logic               deny_q, deny_d;
  logic               xack_q, xack_d;
  logic               xerr_q, xerr_d;
  logic [SPOT_W-1:0]  free_idx;
  logic               none_free;

  lowest_free_enc u_enc (
    .occ       (occ_q),
    .idx       (free_idx),
    .none_free (none_free)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      occ_q   <= '0;
      free_q  <= CNT_W'(N_SPOTS);
      full_q  <= 1'b0;
      spot_q  <= '0;
      eack_q  <= 1'b0;
      deny_q  <= 1'b0;
      xack_q  <= 1'b0;
      xerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      occ_q   <= occ_d;
      free_q  <= free_d;
      full_q  <= full_d;
      spot_q  <= spot_d;
      eack_q  <= eack_d;
      deny_q  <= deny_d;
      xack_q  <= xack_d;
      xerr_q  <= xerr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    occ_d   = occ_q;
    free_d  = free_q;
    full_d  = full_q;
    spot_d  = spot_q;
    eack_d  = 1'b0;
    deny_d  = 1'b0;
    xack_d  = 1'b0;
    xerr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // Exit wins over entry so a freed spot can serve the pending entry.
        if (exit_req) begin
          if (occ_q[exit_spot]) begin
            occ_d[exit_spot] = 1'b0;
            free_d           = free_q + 1'b1;
            full_d           = 1'b0;
            xack_d           = 1'b1;
            tmr_d            = TMR_LOAD;
            state_d          = GATE;
          end else begin
            xerr_d = 1'b1;
          end
        end else if (entry_req) begin
          if (!full_q) begin
            occ_d[free_idx] = 1'b1;
            free_d          = free_q - 1'b1;
            full_d          = (free_q == CNT_W'(1));
            spot_d          = free_idx;
            eack_d          = 1'b1;
            tmr_d           = TMR_LOAD;
            state_d         = GATE;
          end else begin
            deny_d = 1'b1;
          end
        end
      end
      GATE: begin
        if (tmr_q == '0) state_d = IDLE;
        else             tmr_d   = tmr_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gate_open     = (state_q == GATE);
    entry_ack     = eack_q;
    entry_deny    = deny_q;
    exit_ack      = xack_q;
    exit_err      = xerr_q;
    assigned_spot = spot_q;
    occ           = occ_q;
    free_cnt      = free_q;
    full          = full_q;
  end

  // The encoder's view of the map must agree with the registered full flag.
  a_full_consistent: assert property (@(posedge clk) disable iff (!rst_n) none_free == full_q);

endmodule
